sne_cfg_arbiter: RTL
====================

Name: sne_cfg_arbiter

Overview:
Arbitrates the SNE core configuration window (config_addr_o/config_wdata_o/config_we_o) between two requesters: single-word AXI-lite register writes and streamed configuration packets arriving from the NoC.
- Round-robin at transaction granularity; a stream packet holds the window until its TLAST beat.
- Sits in the clk_control domain, between the AXI control slave and the SNE core.
- Provides write and error counters for the control register map.

Parameters:
BW, 32, data width of the stream and of the config data.
GAP, 0, idle cycles inserted after each accepted write beat (0..15).
WIN_BASE, 32'h0000_0000, window base byte address (used only with CFG_ADDR_CHECK_EN).
WIN_SIZE, 32'h0001_0000, window size in bytes (used only with CFG_ADDR_CHECK_EN).

Ports:
clk_control  in  1  control clock
clk_control_rst_high  in  1  asynchronous, active-high reset
cfg_enable  in  1  when low, no new grants are issued
axi_req_valid  in  1  AXI write request valid
axi_req_ready  out  1  AXI write request accepted (combinational)
axi_req_addr  in  32  AXI write byte address
axi_req_wdata  in  BW  AXI write data
cfg_stream_TDATA  in  BW  stream beat: header word first, then data words
cfg_stream_TVALID  in  1  stream beat valid
cfg_stream_TREADY  out  1  stream beat accepted (combinational)
cfg_stream_TLAST  in  1  last beat of the packet
config_addr_o  out  32  SNE config address (registered)
config_wdata_o  out  BW  SNE config data (registered)
config_we_o  out  1  one-cycle write strobe (registered)
grant_o  out  2  one-hot current owner: [0]=AXI, [1]=stream
busy_o  out  1  state != IDLE
wr_count_o  out  32  writes issued; wraps modulo 2^32
err_count_o  out  16  error count; saturates at 16'hFFFF

Behaviour:
Reset:
- All outputs are 0.
- State is IDLE.
- last_grant = stream, so AXI wins the first tie.

States:
IDLE:
- Grant only if cfg_enable=1.
- A single requester wins.
- If both request, the one not equal to last_grant wins.
- AXI grant: axi_req_ready=1 in the same cycle. Addr and data are captured. Next state is GAP_WAIT if GAP>0, else IDLE.
- Stream grant: cfg_stream_TREADY=1 in the same cycle and the header beat is accepted. cur_addr = {TDATA[31:2],2'b00}. Next state is STR_DATA.
- Header beat with TLAST=1: err_count +1, no write, back to IDLE.
STR_DATA:
- cfg_stream_TREADY=1 when no gap is pending; axi_req_ready=0.
- Each accepted beat issues a write to cur_addr; then cur_addr += 4, wrapping modulo 2^32.
- Beat with TLAST=1: last write, next state GAP_WAIT (if GAP>0) or IDLE, last_grant = stream.
- With GAP>0, after each non-last beat TREADY is held low for GAP cycles; the state stays STR_DATA.
GAP_WAIT:
- Count GAP cycles with no grants, then go to IDLE.

Write timing and counters:
- Write latency: config_we_o=1 exactly one cycle after the accepting handshake cycle, with the captured addr/data.
- config_addr_o/config_wdata_o hold their last values when config_we_o=0.
- Throughput: 1 write/cycle at GAP=0; AXI back-to-back accepts are allowed from IDLE.
- wr_count_o increments in the cycle config_we_o is asserted.
- err_count_o does not wrap.

Arbitration:
- last_grant updates on an AXI accept, and on the stream TLAST accept.
- A stream packet is never interrupted; AXI requests wait until the packet completes.
- cfg_enable falling mid-packet: the packet completes normally, then no new grants are made.

Reset mid-operation:
- Everything returns to reset values and the partial packet is discarded.
- After release, the next stream beat is treated as a header.
- No config_we_o is issued for a beat accepted in the reset cycle.

Optional Feature:
CFG_ADDR_CHECK_EN
- Defined: each write address is checked against WIN_BASE <= addr < WIN_BASE+WIN_SIZE. Out-of-window beats still complete their handshake, but config_we_o stays 0, err_count +1 and wr_count is unchanged. A stream packet continues, with cur_addr still advancing.
- Undefined: no check; all writes are issued and WIN_BASE/WIN_SIZE are ignored.

Test Plan:
1. AXI write addr 0x10, data 0xDEADBEEF, GAP=0 -> axi_req_ready=1 in the same cycle; next cycle config_we_o=1, addr 0x10, data 0xDEADBEEF; wr_count_o=1.
2. Stream header 0x103, then data 0xA, 0xB, 0xC with TLAST on 0xC -> writes on consecutive cycles to 0x100/0x104/0x108 with 0xA/0xB/0xC; wr_count_o=3; grant_o=2'b10 during the packet.
3. AXI valid and stream header asserted together after reset -> AXI written first, then the stream packet. A second AXI request raised mid-packet gets axi_req_ready only after the TLAST beat.
4. Header beat with TLAST=1 -> no config_we_o; err_count_o=1; state back to IDLE.
5. GAP=2, stream header + 2 data beats -> TREADY low for 2 cycles between the beats; the two config_we_o pulses are 3 cycles apart; busy_o stays high for the 2 GAP_WAIT cycles after the last beat.
6. Reset pulse after the first data beat of a 4-beat packet, then beats resume -> outputs are 0 during reset; the first post-reset beat is taken as the header; with CFG_ADDR_CHECK_EN, an AXI write to WIN_BASE+WIN_SIZE gives no config_we_o and err_count_o +1.

Source files
------------

// File: rtl/sne_cfg_arbiter.sv
// sne_cfg_arbiter: shares the SNE core configuration window between
// single-word AXI-lite writes and streamed configuration packets.
// Arbitration is round-robin per transaction, and a stream packet keeps the
// window until its TLAST beat. Writes reach the core one cycle after the
// accepting handshake. The module also keeps write and error counters.
// Optional build macro: CFG_ADDR_CHECK_EN enables the address window check.
// When it is defined, writes outside [WIN_BASE, WIN_BASE+WIN_SIZE) are
// dropped and counted as errors.
module sne_cfg_arbiter #(
  parameter int          BW       = 32,
  parameter int          GAP      = 0,
  parameter logic [31:0] WIN_BASE = 32'h0000_0000,
  parameter logic [31:0] WIN_SIZE = 32'h0001_0000
) (
  input  logic          clk_control,
  input  logic          clk_control_rst_high,
  input  logic          cfg_enable,
  input  logic          axi_req_valid,
  output logic          axi_req_ready,
  input  logic [31:0]   axi_req_addr,
  input  logic [BW-1:0] axi_req_wdata,
  input  logic [BW-1:0] cfg_stream_TDATA,
  input  logic          cfg_stream_TVALID,
  output logic          cfg_stream_TREADY,
  input  logic          cfg_stream_TLAST,
  output logic [31:0]   config_addr_o,
  output logic [BW-1:0] config_wdata_o,
  output logic          config_we_o,
  output logic [1:0]    grant_o,
  output logic          busy_o,
  output logic [31:0]   wr_count_o,
  output logic [15:0]   err_count_o
);

  typedef enum logic [1:0] {IDLE, STR_DATA, GAP_WAIT} state_t;

  localparam logic [3:0] GAP_L  = 4'(GAP);
  localparam logic [3:0] GAP_M1 = GAP_L - 4'd1;

  state_t        state_reg, state_next;
  logic          last_grant_reg, last_grant_next;  // 1 = stream was served last
  logic [3:0]    gap_cnt_reg, gap_cnt_next;
  logic [31:0]   cur_addr_reg, cur_addr_next;
  logic          we_reg, we_next;
  logic [31:0]   addr_reg, addr_next;
  logic [BW-1:0] wdata_reg, wdata_next;
  logic [31:0]   wr_count_reg, wr_count_next;
  logic [15:0]   err_count_reg, err_count_next;

  logic          axi_ready_c, str_ready_c;
  logic [1:0]    grant_c;
  logic          issue_c, err_inc_c, in_win_c;
  logic [31:0]   issue_addr_c;
  logic [BW-1:0] issue_data_c;
  logic          pick_axi_c, pick_str_c;

  // Round-robin tie break: on a collision, the side that was not served last wins.
  assign pick_axi_c = axi_req_valid && (!cfg_stream_TVALID || last_grant_reg);
  assign pick_str_c = cfg_stream_TVALID && (!axi_req_valid || !last_grant_reg);

  // Address window check on the write about to be issued.
`ifdef CFG_ADDR_CHECK_EN
  assign in_win_c = ({1'b0, issue_addr_c} >= {1'b0, WIN_BASE}) &&
                    ({1'b0, issue_addr_c} <  ({1'b0, WIN_BASE} + {1'b0, WIN_SIZE}));
`else
  assign in_win_c = 1'b1;
`endif

  // Next-state logic, handshakes, write issue and counter updates.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    gap_cnt_next    = gap_cnt_reg;
    cur_addr_next   = cur_addr_reg;
    we_next         = 1'b0;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    wr_count_next   = wr_count_reg;
    err_count_next  = err_count_reg;
    axi_ready_c     = 1'b0;
    str_ready_c     = 1'b0;
    grant_c         = 2'b00;
    issue_c         = 1'b0;
    err_inc_c       = 1'b0;
    issue_addr_c    = cur_addr_reg;
    issue_data_c    = cfg_stream_TDATA;

    case (state_reg)
      IDLE: begin
        if (cfg_enable) begin
          if (pick_axi_c) begin
            axi_ready_c     = 1'b1;
            grant_c         = 2'b01;
            last_grant_next = 1'b0;
            issue_c         = 1'b1;
            issue_addr_c    = axi_req_addr;
            issue_data_c    = axi_req_wdata;
            if (GAP > 0) begin
              state_next   = GAP_WAIT;
              gap_cnt_next = GAP_M1;
            end
          end else if (pick_str_c) begin
            str_ready_c = 1'b1;
            grant_c     = 2'b10;
            if (cfg_stream_TLAST) begin
              // A packet with only a header carries no data: flag it and drop it.
              err_inc_c       = 1'b1;
              last_grant_next = 1'b1;
            end else begin
              cur_addr_next = {cfg_stream_TDATA[31:2], 2'b00};
              gap_cnt_next  = 4'd0;
              state_next    = STR_DATA;
            end
          end
        end
      end

      STR_DATA: begin
        grant_c = 2'b10;
        if (gap_cnt_reg != 4'd0) begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end else begin
          str_ready_c = 1'b1;
          if (cfg_stream_TVALID) begin
            issue_c       = 1'b1;
            issue_addr_c  = cur_addr_reg;
            issue_data_c  = cfg_stream_TDATA;
            cur_addr_next = cur_addr_reg + 32'd4;
            if (cfg_stream_TLAST) begin
              last_grant_next = 1'b1;
              if (GAP > 0) begin
                state_next   = GAP_WAIT;
                gap_cnt_next = GAP_M1;
              end else begin
                state_next = IDLE;
              end
            end else begin
              gap_cnt_next = GAP_L;
            end
          end
        end
      end

      GAP_WAIT: begin
        if (gap_cnt_reg == 4'd0) state_next = IDLE;
        else                     gap_cnt_next = gap_cnt_reg - 4'd1;
      end

      default: state_next = IDLE;
    endcase

    if (issue_c) begin
      if (in_win_c) begin
        we_next       = 1'b1;
        addr_next     = issue_addr_c;
        wdata_next    = issue_data_c;
        wr_count_next = wr_count_reg + 32'd1;
      end else begin
        err_inc_c = 1'b1;
      end
    end

    if (err_inc_c && (err_count_reg != 16'hFFFF)) err_count_next = err_count_reg + 16'd1;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      gap_cnt_reg    <= 4'd0;
      cur_addr_reg   <= 32'd0;
      we_reg         <= 1'b0;
      addr_reg       <= 32'd0;
      wdata_reg      <= '0;
      wr_count_reg   <= 32'd0;
      err_count_reg  <= 16'd0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      gap_cnt_reg    <= gap_cnt_next;
      cur_addr_reg   <= cur_addr_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      wr_count_reg   <= wr_count_next;
      err_count_reg  <= err_count_next;
    end
  end

  // Handshakes are masked while reset is asserted, so no beat is taken then.
  assign axi_req_ready     = axi_ready_c && !clk_control_rst_high;
  assign cfg_stream_TREADY = str_ready_c && !clk_control_rst_high;
  assign grant_o           = clk_control_rst_high ? 2'b00 : grant_c;
  assign busy_o            = (state_reg != IDLE);
  assign config_we_o       = we_reg;
  assign config_addr_o     = addr_reg;
  assign config_wdata_o    = wdata_reg;
  assign wr_count_o        = wr_count_reg;
  assign err_count_o       = err_count_reg;

endmodule
